// File: rtl/ddr3_dly_pkg.sv
// Shared types and defaults for the DDR3 lane delay-line sequencer.
package ddr3_dly_pkg;
  localparam int DLY_SETTLE_CYC_DEF = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_SET  = 2'b11
  } dly_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LSETTLE,
    ST_PREP,
    ST_MOVE,
    ST_SETTLE,
    ST_DONE
  } dly_state_e;
endpackage

// File: rtl/ddr3_dly_tap_cnt.sv
// Shadow tap counter for one IOD channel: clear wins, then saturating inc, then saturating dec.
module ddr3_dly_tap_cnt #(
  parameter int TAP_W   = 8,
  parameter int TAP_MAX = 127
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [TAP_W-1:0] o_tap
);
  localparam logic [TAP_W-1:0] LP_MAX = TAP_W'(TAP_MAX);
  localparam logic [TAP_W-1:0] LP_ONE = TAP_W'(1);

  logic [TAP_W-1:0] r_tap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tap <= '0;
    end else if (i_clr) begin
      r_tap <= '0;
    end else if (i_inc && (r_tap != LP_MAX)) begin
      r_tap <= r_tap + LP_ONE;
    end else if (i_dec && (r_tap != '0)) begin
      r_tap <= r_tap - LP_ONE;
    end
  end

  assign o_tap = r_tap;
endmodule

// File: rtl/ddr3_lane_dly_ctrl.sv
// Delay-line sequencer for one DDR3 PHY lane: spaced LOAD/DIRECTION/MOVE pulses with shadow taps.
// Define DDR_DLY_BROADCAST_EN to let CMD_CH == NUM_CH drive all channels in lockstep.
module ddr3_lane_dly_ctrl
  import ddr3_dly_pkg::*;
#(
  parameter int NUM_CH     = 9,
  parameter int TAP_W      = 8,
  parameter int TAP_MAX    = 127,
  parameter int SETTLE_CYC = DLY_SETTLE_CYC_DEF
) (
  input  logic                        FAB_CLK,
  input  logic                        ARST,
  input  logic                        CMD_VALID,
  output logic                        CMD_READY,
  input  logic [$clog2(NUM_CH+1)-1:0] CMD_CH,
  input  logic [1:0]                  CMD_OP,
  input  logic [TAP_W-1:0]            CMD_STEPS,
  output logic                        DONE,
  output logic                        ERR,
  output logic [NUM_CH*TAP_W-1:0]     TAP_VAL,
  output logic [NUM_CH-1:0]           DELAY_LINE_MOVE,
  output logic [NUM_CH-1:0]           DELAY_LINE_DIRECTION,
  output logic [NUM_CH-1:0]           DELAY_LINE_LOAD,
  input  logic [NUM_CH-1:0]           DELAY_LINE_OUT_OF_RANGE
);
  localparam int CHW   = $clog2(NUM_CH + 1);
  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CHW-1:0]   BCAST_CH  = CHW'(NUM_CH);
  localparam logic [TAP_W-1:0] TAP_MAX_V = TAP_W'(TAP_MAX);
  localparam logic [TAP_W-1:0] TAP_ONE   = TAP_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYC - 1);

  dly_state_e        r_state, w_state_nxt;
  dly_op_e           r_op, w_op_nxt;
  logic [NUM_CH-1:0] r_mask, w_mask_nxt;
  logic [TAP_W-1:0]  r_rem, w_rem_nxt;
  logic              r_err, w_err_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_live;

  logic [TAP_W-1:0]  w_tap [NUM_CH];
  logic [NUM_CH-1:0] w_clr, w_inc, w_dec;
  logic [NUM_CH-1:0] w_act, w_clip, w_edge;
  logic [NUM_CH-1:0] w_cmd_mask;
  logic              w_cmd_legal;
  logic              w_oor, w_more;

  // One remaining-step counter serves every channel: a channel drops out once its own tap hits the limit.
  always_comb begin
    w_act  = '0;
    w_clip = '0;
    w_edge = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_op == OP_DEC) begin
        w_act[c]  = r_mask[c] && (r_rem != '0) && (w_tap[c] != '0);
        w_clip[c] = r_mask[c] && (w_tap[c] < r_rem);
        w_edge[c] = (w_tap[c] == TAP_ONE);
      end else begin
        w_act[c]  = r_mask[c] && (r_rem != '0) && (w_tap[c] != TAP_MAX_V);
        w_clip[c] = r_mask[c] && ((TAP_MAX_V - w_tap[c]) < r_rem);
        w_edge[c] = (w_tap[c] == (TAP_MAX_V - TAP_ONE));
      end
    end
  end

  assign w_oor  = |(DELAY_LINE_OUT_OF_RANGE & r_mask);
  assign w_more = (r_rem > TAP_ONE) && (|(w_act & ~w_edge));

  always_comb begin
    w_cmd_legal = 1'b0;
    w_cmd_mask  = '0;
    if (CMD_CH < BCAST_CH) begin
      w_cmd_legal = 1'b1;
      w_cmd_mask  = NUM_CH'(1) << CMD_CH;
    end
`ifdef DDR_DLY_BROADCAST_EN
    else if (CMD_CH == BCAST_CH) begin
      w_cmd_legal = 1'b1;
      w_cmd_mask  = '1;
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_mask_nxt  = r_mask;
    w_rem_nxt   = r_rem;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    w_clr       = '0;
    w_inc       = '0;
    w_dec       = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (CMD_VALID && r_live) begin
          w_op_nxt   = dly_op_e'(CMD_OP);
          w_rem_nxt  = CMD_STEPS;
          w_mask_nxt = w_cmd_mask;
          w_err_nxt  = !w_cmd_legal;
          if (!w_cmd_legal) begin
            w_state_nxt = ST_DONE;
          end else if ((dly_op_e'(CMD_OP) == OP_LOAD) || (dly_op_e'(CMD_OP) == OP_SET)) begin
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_PREP;
          end
        end
      end
      ST_LOAD: begin
        w_clr       = r_mask;
        w_cnt_nxt   = CNT_LAST;
        w_state_nxt = ST_LSETTLE;
      end
      ST_LSETTLE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (r_op == OP_SET) begin
          // SET continues as an INC from tap 0; a target beyond range is clipped.
          w_op_nxt = OP_INC;
          if (r_rem > TAP_MAX_V) begin
            w_rem_nxt = TAP_MAX_V;
            w_err_nxt = 1'b1;
          end
          w_state_nxt = ST_PREP;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_PREP: begin
        if (|w_clip) w_err_nxt = 1'b1;
        w_state_nxt = (|w_act) ? ST_MOVE : ST_DONE;
      end
      ST_MOVE: begin
        w_cnt_nxt   = CNT_LAST;
        w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (w_oor) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          if (r_op == OP_DEC) w_dec = w_act;
          else                w_inc = w_act;
          w_rem_nxt   = r_rem - TAP_ONE;
          w_state_nxt = w_more ? ST_MOVE : ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      r_state <= ST_IDLE;
      r_op    <= OP_LOAD;
      r_mask  <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_mask  <= w_mask_nxt;
      r_rem   <= w_rem_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
      r_live  <= 1'b1;
    end
  end

  // Outputs decode straight from state so an asserted ARST silences them immediately.
  assign CMD_READY            = r_live && (r_state == ST_IDLE);
  assign DONE                 = (r_state == ST_DONE);
  assign ERR                  = (r_state == ST_DONE) && r_err;
  assign DELAY_LINE_LOAD      = (r_state == ST_LOAD) ? r_mask : '0;
  assign DELAY_LINE_MOVE      = (r_state == ST_MOVE) ? w_act : '0;
  assign DELAY_LINE_DIRECTION = (((r_state == ST_PREP) || (r_state == ST_MOVE) ||
                                  (r_state == ST_SETTLE)) && (r_op == OP_INC)) ? r_mask : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ddr3_dly_tap_cnt #(
      .TAP_W   (TAP_W),
      .TAP_MAX (TAP_MAX)
    ) u_tap_cnt (
      .i_clk (FAB_CLK),
      .i_rst (ARST),
      .i_clr (w_clr[g]),
      .i_inc (w_inc[g]),
      .i_dec (w_dec[g]),
      .o_tap (w_tap[g])
    );
    assign TAP_VAL[g*TAP_W +: TAP_W] = w_tap[g];
  end
endmodule

// File: tb/tb_ddr3_lane_dly_ctrl.sv
// Bench for ddr3_lane_dly_ctrl: directed vector table, reset corner cases, then random commands vs a tap model.
module tb_ddr3_lane_dly_ctrl;
  localparam int NUM_CH  = 9;
  localparam int TAP_W   = 8;
  localparam int TAP_MAX = 127;
  localparam int S       = 4;
  localparam int CHW     = $clog2(NUM_CH + 1);
  localparam int T_LOAD = 0, T_INC = 1, T_DEC = 2, T_SET = 3;
`ifdef DDR_DLY_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic                    FAB_CLK = 1'b0;
  logic                    ARST;
  logic                    CMD_VALID;
  logic                    CMD_READY;
  logic [CHW-1:0]          CMD_CH;
  logic [1:0]              CMD_OP;
  logic [TAP_W-1:0]        CMD_STEPS;
  logic                    DONE, ERR;
  logic [NUM_CH*TAP_W-1:0] TAP_VAL;
  logic [NUM_CH-1:0]       DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD;
  logic [NUM_CH-1:0]       DELAY_LINE_OUT_OF_RANGE;

  ddr3_lane_dly_ctrl #(
    .NUM_CH(NUM_CH), .TAP_W(TAP_W), .TAP_MAX(TAP_MAX), .SETTLE_CYC(S)
  ) dut (
    .FAB_CLK(FAB_CLK), .ARST(ARST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_CH(CMD_CH), .CMD_OP(CMD_OP), .CMD_STEPS(CMD_STEPS), .DONE(DONE), .ERR(ERR),
    .TAP_VAL(TAP_VAL), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION), .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int m_tap [NUM_CH];
  int exp_lat, exp_err, exp_first;
  int exp_moves [NUM_CH];
  int exp_loads [NUM_CH];
  int obs_lat, obs_err, obs_first, obs_gap_bad, obs_dir_bad;
  int obs_moves [NUM_CH];
  int obs_loads [NUM_CH];

  typedef struct {
    int ch; int op; int steps; int oor_at;
    int tap_ch; int e_lat; int e_err; int e_tap; int e_moves;
  } vec_t;
  vec_t vt [11];

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, req);
    end
  endtask

  function automatic int tap_of(input int c);
    logic [TAP_W-1:0] v;
    v = TAP_VAL[c*TAP_W +: TAP_W];
    return int'(v);
  endfunction

  // Reference: each targeted channel makes min(steps, room) moves; the command lasts as long as the longest one.
  task automatic model_cmd(input int ch, input int op, input int steps, input int oor_at);
    int n, base, kmax, lim, adv;
    int k [NUM_CH];
    bit legal, is_inc, tg;
    n = steps; exp_err = 0; exp_first = 0; kmax = 0;
    for (int c = 0; c < NUM_CH; c++) begin exp_moves[c] = 0; exp_loads[c] = 0; k[c] = 0; end
    legal = (ch < NUM_CH) || (BCAST && ch == NUM_CH);
    if (!legal) begin exp_lat = 1; exp_err = 1; return; end
    if (op == T_LOAD || op == T_SET)
      for (int c = 0; c < NUM_CH; c++)
        if (ch == NUM_CH || c == ch) begin m_tap[c] = 0; exp_loads[c] = 1; end
    if (op == T_LOAD) begin exp_lat = 2 + S; return; end
    is_inc = (op != T_DEC);
    base = 2;
    if (op == T_SET) begin
      base = 3 + S;
      if (n > TAP_MAX) begin n = TAP_MAX; exp_err = 1; end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      tg = (ch == NUM_CH) || (c == ch);
      if (tg) begin
        lim  = is_inc ? TAP_MAX - m_tap[c] : m_tap[c];
        k[c] = (n < lim) ? n : lim;
        if (k[c] < n) exp_err = 1;
        if (k[c] > kmax) kmax = k[c];
      end
    end
    if (kmax > 0) exp_first = base;
    if (oor_at > 0 && oor_at <= kmax) begin
      exp_err = 1;
      exp_lat = base + oor_at * (S + 1);
      for (int c = 0; c < NUM_CH; c++) begin
        exp_moves[c] = (k[c] < oor_at) ? k[c] : oor_at;
        adv = (k[c] < oor_at - 1) ? k[c] : oor_at - 1;
        m_tap[c] += is_inc ? adv : -adv;
      end
    end else begin
      exp_lat = base + kmax * (S + 1);
      for (int c = 0; c < NUM_CH; c++) begin
        exp_moves[c] = k[c];
        m_tap[c] += is_inc ? k[c] : -k[c];
      end
    end
  endtask

  task automatic run_cmd(input int ch, input int op, input int steps, input int oor_at);
    int w;
    int last [NUM_CH];
    bit seen_done;
    obs_lat = -1; obs_err = -1; obs_first = 0; obs_gap_bad = 0; obs_dir_bad = 0;
    for (int c = 0; c < NUM_CH; c++) begin obs_moves[c] = 0; obs_loads[c] = 0; last[c] = 0; end
    w = 0;
    while (CMD_READY !== 1'b1 && w < 50) begin @(negedge FAB_CLK); w++; end
    chk("ready_before_cmd", CMD_READY, 1);
    CMD_CH = CHW'(ch); CMD_OP = 2'(op); CMD_STEPS = TAP_W'(steps); CMD_VALID = 1'b1;
    @(posedge FAB_CLK);
    seen_done = 1'b0;
    for (int cyc = 1; cyc <= 2000 && !seen_done; cyc++) begin
      @(negedge FAB_CLK);
      CMD_VALID = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (DELAY_LINE_MOVE[c]) begin
          obs_moves[c]++;
          if (obs_first == 0) obs_first = cyc;
          if (last[c] > 0 && cyc - last[c] != S + 1) obs_gap_bad++;
          last[c] = cyc;
          if (DELAY_LINE_DIRECTION[c] !== (op != T_DEC)) obs_dir_bad++;
        end
        if (DELAY_LINE_LOAD[c]) obs_loads[c]++;
      end
      if (oor_at > 0 && ch < NUM_CH && obs_moves[ch] == oor_at) DELAY_LINE_OUT_OF_RANGE[ch] = 1'b1;
      if (DONE === 1'b1) begin seen_done = 1'b1; obs_lat = cyc; obs_err = int'(ERR); end
    end
    DELAY_LINE_OUT_OF_RANGE = '0;
  endtask

  task automatic verify(input string tag);
    chk({tag, "_done_lat"}, obs_lat, exp_lat);
    chk({tag, "_err"}, obs_err, exp_err);
    chk({tag, "_first_move"}, obs_first, exp_first);
    chk({tag, "_move_spacing_bad"}, obs_gap_bad, 0);
    chk({tag, "_direction_bad"}, obs_dir_bad, 0);
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("%s_moves%0d", tag, c), obs_moves[c], exp_moves[c]);
      chk($sformatf("%s_loads%0d", tag, c), obs_loads[c], exp_loads[c]);
      chk($sformatf("%s_tap%0d", tag, c), tap_of(c), m_tap[c]);
    end
  endtask

  initial begin
    vt[0]  = '{3,  T_LOAD, 0,   0, 3, 6,   0, 0,   0};
    vt[1]  = '{0,  T_INC,  5,   0, 0, 27,  0, 5,   5};
    vt[2]  = '{0,  T_SET,  125, 0, 0, 632, 0, 125, 125};
    vt[3]  = '{0,  T_INC,  10,  0, 0, 12,  1, 127, 2};
    vt[4]  = '{0,  T_DEC,  200, 0, 0, 637, 1, 0,   127};
    vt[5]  = '{8,  T_SET,  40,  0, 8, 207, 0, 40,  40};
    vt[6]  = '{8,  T_INC,  6,   3, 8, 17,  1, 42,  3};
    vt[7]  = '{2,  T_INC,  0,   0, 2, 2,   0, 0,   0};
    vt[8]  = '{1,  T_DEC,  1,   0, 1, 2,   1, 0,   0};
    vt[9]  = '{12, T_INC,  5,   0, 4, 1,   1, 0,   0};
`ifdef DDR_DLY_BROADCAST_EN
    vt[10] = '{9,  T_INC,  3,   0, 0, 17,  0, 3,   3};
`else
    vt[10] = '{9,  T_INC,  3,   0, 0, 1,   1, 0,   0};
`endif

    for (int c = 0; c < NUM_CH; c++) m_tap[c] = 0;
    ARST = 1'b1; CMD_VALID = 1'b0; CMD_CH = '0; CMD_OP = '0; CMD_STEPS = '0;
    DELAY_LINE_OUT_OF_RANGE = '0;
    repeat (3) @(negedge FAB_CLK);
    chk("reset_outputs", {CMD_READY, DONE, ERR, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD}, 0);
    chk("reset_taps_zero", (TAP_VAL == '0), 1);
    ARST = 1'b0;
    #1 chk("ready_low_at_release", CMD_READY, 0);
    @(posedge FAB_CLK);
    #1 chk("ready_after_first_clk", CMD_READY, 1);

    for (int i = 0; i < 11; i++) begin
      model_cmd(vt[i].ch, vt[i].op, vt[i].steps, vt[i].oor_at);
      run_cmd(vt[i].ch, vt[i].op, vt[i].steps, vt[i].oor_at);
      verify($sformatf("v%0d", i));
      chk($sformatf("v%0d_tbl_lat", i), obs_lat, vt[i].e_lat);
      chk($sformatf("v%0d_tbl_err", i), obs_err, vt[i].e_err);
      chk($sformatf("v%0d_tbl_tap", i), tap_of(vt[i].tap_ch), vt[i].e_tap);
      chk($sformatf("v%0d_tbl_moves", i), obs_moves[vt[i].tap_ch], vt[i].e_moves);
    end

    // ARST during the second settle of INC ch5 by 4.
    begin
      int mv, w;
      mv = 0; w = 0;
      while (CMD_READY !== 1'b1 && w < 50) begin @(negedge FAB_CLK); w++; end
      CMD_CH = CHW'(5); CMD_OP = 2'(T_INC); CMD_STEPS = TAP_W'(4); CMD_VALID = 1'b1;
      @(posedge FAB_CLK);
      for (int cyc = 0; cyc < 100 && mv < 2; cyc++) begin
        @(negedge FAB_CLK);
        CMD_VALID = 1'b0;
        if (DELAY_LINE_MOVE[5]) mv++;
      end
      @(negedge FAB_CLK);
      chk("arst_pre_dir", DELAY_LINE_DIRECTION[5], 1);
      chk("arst_pre_tap5", tap_of(5), 1);
      #2 ARST = 1'b1;
      #1;
      chk("arst_outputs_zero", {CMD_READY, DONE, ERR, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD}, 0);
      chk("arst_taps_zero", (TAP_VAL == '0), 1);
      @(negedge FAB_CLK);
      ARST = 1'b0;
      #1 chk("arst_ready_low_at_release", CMD_READY, 0);
      @(posedge FAB_CLK);
      #1 chk("arst_ready_after_clk", CMD_READY, 1);
      for (int c = 0; c < NUM_CH; c++) m_tap[c] = 0;
    end

    for (int i = 0; i < 25; i++) begin
      int ch, op, steps;
      ch = $urandom_range(0, NUM_CH);
      op = $urandom_range(0, 3);
      steps = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TAP_MAX + 40) : $urandom_range(0, 12);
      if (op == T_SET && steps > TAP_MAX) steps = TAP_MAX;
      model_cmd(ch, op, steps, 0);
      run_cmd(ch, op, steps, 0);
      verify($sformatf("r%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ddr3_lane_dly_ctrl.md
# ddr3_lane_dly_ctrl

Parametrised delay-line sequencer for a DDR3 PHY lane. It sits between the training/calibration logic and the per-bit IOD instances (DQ and DM) of one lane. It turns tap commands (load, increment, decrement, set) into correctly spaced DELAY_LINE_LOAD, DELAY_LINE_DIRECTION and DELAY_LINE_MOVE pulses. It keeps a shadow tap count per channel, saturates at the tap range limits, and aborts a command when the IOD reports out-of-range.

## Interface
Parameters:
- NUM_CH, 9, number of controlled IOD channels (8 DQ + 1 DM).
- TAP_W, 8, tap counter and step-count width.
- TAP_MAX, 127, highest legal tap value.
- SETTLE_CYC, 4, idle cycles after every LOAD or MOVE pulse, ≥1.

Ports:
- FAB_CLK  in  1  fabric clock; all logic on its rising edge.
- ARST  in  1  reset, asynchronous, active-high.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  controller idle; command accepted when VALID&&READY.
- CMD_CH  in  $clog2(NUM_CH+1)  target channel; value NUM_CH = broadcast (see Configuration).
- CMD_OP  in  2  00 LOAD, 01 INC, 10 DEC, 11 SET.
- CMD_STEPS  in  TAP_W  step count (INC/DEC) or absolute target (SET).
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  valid with DONE: clip, out-of-range abort or illegal channel.
- TAP_VAL  out  NUM_CH*TAP_W  shadow tap per channel, channel i at [i*TAP_W +: TAP_W].
- DELAY_LINE_MOVE  out  NUM_CH  per-channel move pulse.
- DELAY_LINE_DIRECTION  out  NUM_CH  1 = increment.
- DELAY_LINE_LOAD  out  NUM_CH  per-channel load pulse.
- DELAY_LINE_OUT_OF_RANGE  in  NUM_CH  IOD range flag.

## Operation
- States: IDLE, LOAD, LSETTLE, PREP, MOVE, SETTLE, DONE.
- IDLE: CMD_READY=1. On accept, latch CH/OP/STEPS.
  - Illegal CH goes straight to DONE with ERR=1 and no pulses.
  - LOAD and SET go to LOAD.
  - INC and DEC go to PREP.
- LOAD: LOAD=1 on the target for 1 cycle, and the target tap is set to 0. Then LSETTLE for SETTLE_CYC cycles.
- After LSETTLE: LOAD goes to DONE. SET goes to PREP as INC with steps = min(STEPS, TAP_MAX).
- PREP: DIRECTION driven to its final value and held until DONE. Remaining steps computed; if remaining = 0, go to DONE.
- Clip: INC steps are limited to TAP_MAX−tap. DEC steps are limited to tap. Any limitation sets the ERR flag.
- MOVE: MOVE=1 on the target for 1 cycle. Then SETTLE.
- SETTLE: SETTLE_CYC cycles. On the last cycle, sample OUT_OF_RANGE for the target.
  - If high: the tap is not updated, remaining steps are dropped, ERR is set, go to DONE.
  - Else: tap ±1, and remaining steps −1.
  - Go to MOVE if steps remain, else DONE.
- DONE: DONE=1 for 1 cycle with ERR, then IDLE.
- Inputs other than CMD_VALID are ignored outside IDLE.

## Timing
- Reset values: all outputs 0, TAP_VAL all 0, state IDLE. CMD_READY rises on the first clock after ARST deasserts.
- Accept at cycle T:
  - INC/DEC of N unclipped steps: first MOVE at T+2, successive MOVEs every SETTLE_CYC+1 cycles, DONE at T+2+N·(1+SETTLE_CYC).
  - N=0: DONE at T+2.
  - LOAD: pulse at T+1, DONE at T+2+SETTLE_CYC.
  - SET to N: DONE at T+3+SETTLE_CYC+N·(1+SETTLE_CYC).
- The next command can be accepted at DONE+1.
- ARST mid-command: pulses drop in the same cycle and taps zero. The caller must issue LOAD to resync the IOD.

## Configuration
- DDR_DLY_BROADCAST_EN defined: CMD_CH = NUM_CH addresses all channels in lockstep.
  - DIRECTION, MOVE and LOAD are driven on every channel.
  - Clip is applied per channel; a channel that reaches its limit stops receiving MOVE pulses.
  - The command ends when every channel is finished. OUT_OF_RANGE on any channel aborts all channels.
- Undefined: CMD_CH = NUM_CH is illegal and returns DONE+ERR with no pulses.

## Structure
- Package ddr3_dly_pkg holds:
  - the CMD_OP enum (OP_LOAD, OP_INC, OP_DEC, OP_SET);
  - the FSM state enum;
  - a default SETTLE_CYC constant.
- Sub-module ddr3_dly_tap_cnt: one per channel, a saturating TAP_W counter with clear, inc and dec enables. Instantiated in a generate loop.

## Test plan
- Reset, then LOAD ch3 (SETTLE_CYC=4) → LOAD[3] pulses at T+1, DONE at T+6, TAP_VAL[3]=0, ERR=0.
- INC ch0 by 5 → five MOVE[0] pulses 5 cycles apart with DIRECTION[0]=1, DONE at T+27, TAP0=5.
- INC ch0 at tap 125 by 10 → 2 MOVEs, TAP0=127, DONE with ERR=1. Then DEC by 200 → 127 MOVEs, TAP0=0, ERR=1.
- SET ch8 to 40 → LOAD pulse, then 40 MOVEs, TAP8=40. Then raise OUT_OF_RANGE[8] during the 3rd step of INC 6 → TAP8=42, DONE+ERR, no further MOVEs.
- CMD_CH=9 → with macro: all 9 channels INC 3, TAP all 3. Without macro: DONE+ERR at T+1, no pulses.
- Assert ARST during the 2nd settle of an INC 4 → all outputs 0 in the same cycle, TAP_VAL 0, CMD_READY=1 one cycle after release.
